// File: rtl/clock_div_gen.sv
// Programmable divided-clock generator with rise/fall strobes, start phase and
// period-boundary reconfiguration. Optional pause/HOLD: define CLOCK_DIV_GEN_PAUSE_EN.
module clock_div_gen #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 4
) (
    input  logic             clock,
    input  logic             rst,
`ifdef CLOCK_DIV_GEN_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             locked,
    output logic [CNT_W-1:0] period_cnt
);

`ifdef CLOCK_DIV_GEN_PAUSE_EN
    typedef enum logic [1:0] {ALIGN, RUN, HOLD} state_t;
`else
    typedef enum logic [1:0] {ALIGN, RUN} state_t;
`endif

    localparam logic [CNT_W-1:0] ZERO    = '0;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phs_q, phs_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] act_phase_q, act_phase_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [CNT_W-1:0] pend_phase_q, pend_phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] last;

    assign half = act_div_q >> 1;
    assign last = act_div_q - ONE;

    // Config handshake: a word transfers in any cycle with cfg_valid && cfg_ready.
    // A legal word (div >= 2) occupies the single pending slot, which also drops
    // cfg_ready; the slot is freed (cfg_ready high again) the cycle after it is
    // loaded at a period boundary. An illegal word only pulses cfg_err.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phs_d        = phs_q;
        act_div_d    = act_div_q;
        act_phase_d  = act_phase_q;
        pend_div_d   = pend_div_q;
        pend_phase_d = pend_phase_q;
        period_d     = period_q;
        ready_d      = ready_q;
        err_d        = 1'b0;
        clk_d        = clk_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        locked_d     = locked_q;

        case (state_q)
            ALIGN: begin
                if (phs_q == act_phase_q) begin
                    state_d = RUN;
                    cnt_d   = ZERO;
                    clk_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    phs_d = phs_q + ONE;
                end
            end
            RUN: begin
                if (cnt_q == last) begin
                    period_d = period_q + ONE;
                    locked_d = 1'b1;
`ifdef CLOCK_DIV_GEN_PAUSE_EN
                    if (pause) begin
                        state_d  = HOLD;
                        locked_d = 1'b0;
                        phs_d    = ZERO;
                    end else
`endif
                    if (!ready_q) begin
                        // Pending config becomes active; the low phase hold restarts.
                        act_div_d   = pend_div_q;
                        act_phase_d = pend_phase_q;
                        ready_d     = 1'b1;
                        locked_d    = 1'b0;
                        state_d     = ALIGN;
                        phs_d       = ZERO;
                    end else begin
                        cnt_d  = ZERO;
                        clk_d  = 1'b1;
                        rise_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == half - ONE) begin
                        clk_d  = 1'b0;
                        fall_d = 1'b1;
                    end
                end
            end
`ifdef CLOCK_DIV_GEN_PAUSE_EN
            HOLD: begin
                if (!pause) begin
                    if (!ready_q) begin
                        act_div_d   = pend_div_q;
                        act_phase_d = pend_phase_q;
                        ready_d     = 1'b1;
                        state_d     = ALIGN;
                        phs_d       = ZERO;
                    end else if (act_phase_q == ZERO) begin
                        // Exit behaves as the first ALIGN cycle, so phase 0 rises at once.
                        state_d = RUN;
                        cnt_d   = ZERO;
                        clk_d   = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ALIGN;
                        phs_d   = ONE;
                    end
                end
            end
`endif
            default: state_d = ALIGN;
        endcase

        if (cfg_valid && ready_q) begin
            if (cfg_div >= TWO) begin
                pend_div_d   = cfg_div;
                pend_phase_d = cfg_phase;
                ready_d      = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= ALIGN;
            cnt_q        <= ZERO;
            phs_q        <= ZERO;
            act_div_q    <= DEF_DIV_C;
            act_phase_q  <= ZERO;
            pend_div_q   <= ZERO;
            pend_phase_q <= ZERO;
            period_q     <= ZERO;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            clk_q        <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phs_q        <= phs_d;
            act_div_q    <= act_div_d;
            act_phase_q  <= act_phase_d;
            pend_div_q   <= pend_div_d;
            pend_phase_q <= pend_phase_d;
            period_q     <= period_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            clk_q        <= clk_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            locked_q     <= locked_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign cfg_err    = err_q;
    assign clk_out    = clk_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign locked     = locked_q;
    assign period_cnt = period_q;

endmodule

// File: tb/tb_clock_div_gen.sv
// Self-checking bench for clock_div_gen: behavioural model feeds an expected queue,
// plus directed checks against hand-derived constants.
module tb_clock_div_gen;
  localparam int CW = 8;
  localparam int W  = 14;

  logic          clock = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_div;
  logic [CW-1:0] cfg_phase;
  logic          cfg_err;
  logic          clk_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic          locked;
  logic [CW-1:0] period_cnt;
`ifdef CLOCK_DIV_GEN_PAUSE_EN
  logic          pause;
`endif

  clock_div_gen #(.CNT_W(CW), .DEF_DIV(4)) dut (
    .clock      (clock),
    .rst        (rst),
`ifdef CLOCK_DIV_GEN_PAUSE_EN
    .pause      (pause),
`endif
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .locked     (locked),
    .period_cnt (period_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", tag, $time);
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 = aligning (low hold), 1 = running, 2 = paused
  logic [1:0]    m_st;
  logic [CW-1:0] m_pos, m_phs, m_div, m_phase, m_pdiv, m_pphase, m_pcnt;
  logic          m_clk, m_rise, m_fall, m_lock, m_rdy, m_err;

  task automatic model_step(input logic r, input logic v, input logic [CW-1:0] d,
                            input logic [CW-1:0] p, input logic ps);
    logic acc;
    logic clk_n;
    if (r) begin
      m_st = 0; m_pos = 0; m_phs = 0; m_div = 4; m_phase = 0;
      m_pdiv = 0; m_pphase = 0; m_pcnt = 0;
      m_clk = 0; m_rise = 0; m_fall = 0; m_lock = 0; m_rdy = 1; m_err = 0;
    end else begin
      acc = v && m_rdy;
      case (m_st)
        2'd0: begin
          if (m_phs == m_phase) begin m_st = 1; m_pos = 0; end
          else m_phs = m_phs + 1;
        end
        2'd1: begin
          if (m_pos == m_div - 1) begin
            m_pcnt = m_pcnt + 1;
            m_lock = 1;
            if (ps) begin
              m_st = 2; m_lock = 0; m_phs = 0;
            end else if (!m_rdy) begin
              m_div = m_pdiv; m_phase = m_pphase; m_rdy = 1;
              m_lock = 0; m_st = 0; m_phs = 0;
            end else begin
              m_pos = 0;
            end
          end else begin
            m_pos = m_pos + 1;
          end
        end
        default: begin
          if (!ps) begin
            if (!m_rdy) begin
              m_div = m_pdiv; m_phase = m_pphase; m_rdy = 1; m_st = 0; m_phs = 0;
            end else if (m_phase == 0) begin
              m_st = 1; m_pos = 0;
            end else begin
              m_st = 0; m_phs = 1;
            end
          end
        end
      endcase
      // Waveform derived from position in period, pulses from its edges.
      clk_n  = (m_st == 1) && (m_pos < (m_div >> 1));
      m_rise = clk_n && !m_clk;
      m_fall = !clk_n && m_clk;
      m_clk  = clk_n;
      m_err  = 0;
      if (acc) begin
        if (d >= 2) begin m_pdiv = d; m_pphase = p; m_rdy = 0; end
        else m_err = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic v, input logic [CW-1:0] d,
                      input logic [CW-1:0] p, input logic ps);
    logic [W-1:0] e;
    @(negedge clock);
    rst = r; cfg_valid = v; cfg_div = d; cfg_phase = p;
`ifdef CLOCK_DIV_GEN_PAUSE_EN
    pause = ps;
`endif
    model_step(r, v, d, p, ps);
    exp_q.push_back({m_clk, m_rise, m_fall, m_lock, m_rdy, m_err, m_pcnt});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      timeout("sb_empty");
    end else begin
      e = exp_q.pop_front();
      check("sb", {18'd0, clk_out, rise_pulse, fall_pulse, locked, cfg_ready, cfg_err, period_cnt},
            {18'd0, e});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  // Directed DEF_DIV=4 sequence right after reset release.
  task automatic run_default(input string tag);
    int pat[4];
    pat = '{1, 1, 0, 0};
    for (int k = 1; k <= 13; k++) begin
      idle(1);
      check({tag, "_clk"}, clk_out, pat[(k - 1) % 4]);
      check({tag, "_rise"}, rise_pulse, (k % 4) == 1);
      check({tag, "_fall"}, fall_pulse, (k % 4) == 3);
      check({tag, "_lock"}, locked, k >= 5);
    end
    check({tag, "_pcnt13"}, period_cnt, 3);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int guard;
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_phase = '0;
`ifdef CLOCK_DIV_GEN_PAUSE_EN
    pause = 1'b0;
`endif
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check("rst_clk", clk_out, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_pcnt", period_cnt, 0);
    check("rst_lock", locked, 0);

    run_default("def");

    // div=5 phase=3 offered mid-period (cycle 14, second cycle of the period)
    tick(1'b0, 1'b1, 8'd5, 8'd3, 1'b0);
    check("acc_ready_low", cfg_ready, 0);
    idle(2);
    check("pend_ready_low", cfg_ready, 0);
    idle(25);

    // illegal divides
    tick(1'b0, 1'b1, 8'd1, 8'd0, 1'b0);
    check("err_div1", cfg_err, 1);
    check("err_div1_ready", cfg_ready, 1);
    idle(1);
    check("err_clear", cfg_err, 0);
    tick(1'b0, 1'b1, 8'd0, 8'd2, 1'b0);
    check("err_div0", cfg_err, 1);
    idle(6);

    // accept on exact period-end cycle
    guard = 0;
    while (!(m_st == 1 && m_pos == m_div - 1) && guard < 20) begin
      idle(1);
      guard++;
    end
    if (guard >= 20) timeout("wait_period_end");
    tick(1'b0, 1'b1, 8'd6, 8'd0, 1'b0);
    check("pe_rise_old_div", rise_pulse, 1);
    check("pe_ready_low", cfg_ready, 0);
    idle(30);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 7)), 8'($urandom_range(0, 4)), 1'b0);
    end

    // reset while high with a config pending
    tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    idle(1);
    tick(1'b0, 1'b1, 8'd7, 8'd2, 1'b0);
    check("mid_clk_high", clk_out, 1);
    check("mid_pending", cfg_ready, 0);
    tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    check("mid_rst_clk", clk_out, 0);
    check("mid_rst_ready", cfg_ready, 1);
    check("mid_rst_pcnt", period_cnt, 0);
    run_default("after_rst");

    // period_cnt wrap with div=2, then maximal phase
    tick(1'b0, 1'b1, 8'd2, 8'd0, 1'b0);
    idle(560);
    tick(1'b0, 1'b1, 8'd3, 8'd255, 1'b0);
    idle(280);

`ifdef CLOCK_DIV_GEN_PAUSE_EN
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("pause_clk", clk_out, 0);
    idle(20);
    tick(1'b0, 1'b1, 8'd4, 8'd1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    idle(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
